// File: rtl/s_mem_readback.sv
// s_mem_readback: scans the S-array RAM, checking identity (mode 0) or permutation (mode 1).
// Latency LEN+1 edges from accepted en to valid; en is ignored while rdy=0, no queuing.
module s_mem_readback #(
  parameter int LEN = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  output logic       rdy,
  output logic [7:0] addr,
  input  logic [7:0] rddata,
  output logic       wren,
  output logic       valid,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [7:0] fail_addr,
  output logic [7:0] fail_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

  localparam logic [8:0] LEN_CNT   = 9'(LEN);
  localparam logic [7:0] LAST_ADDR = 8'(LEN - 1);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_start;
  logic         w_cmp;
  logic         w_last;

  logic         r_mode;
  logic [8:0]   r_cnt;
  logic [7:0]   r_addr;
  logic [255:0] r_seen;
  logic [8:0]   r_acc_cnt;
  logic         r_acc_hit;
  logic [7:0]   r_acc_fa;
  logic [7:0]   r_acc_fd;
  logic         r_pass;
  logic [8:0]   r_err_count;
  logic [7:0]   r_fail_addr;
  logic [7:0]   r_fail_data;

  logic [7:0]   w_cmp_addr;
  logic         w_err;
  logic         w_new_first;
  logic [8:0]   w_acc_cnt_nxt;
  logic [7:0]   w_fa_nxt;
  logic [7:0]   w_fd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // DONE also accepts en so a held request runs scans back to back.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_cmp       = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_start     = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_cmp = (r_cnt != 9'd0);
        if (r_cnt == LEN_CNT) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (en) begin
          w_start     = 1'b1;
          w_state_nxt = S_READ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Data compared this edge belongs to the address issued two edges earlier.
  assign w_cmp_addr    = r_cnt[7:0] - 8'd1;
  assign w_err         = w_cmp && (r_mode ? r_seen[rddata] : (rddata != w_cmp_addr));
  assign w_new_first   = w_err && !r_acc_hit;
  assign w_acc_cnt_nxt = r_acc_cnt + {8'd0, w_err};
  assign w_fa_nxt      = w_new_first ? w_cmp_addr : r_acc_fa;
  assign w_fd_nxt      = w_new_first ? rddata     : r_acc_fd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= 1'b0;
      r_cnt       <= 9'd0;
      r_addr      <= 8'd0;
      r_seen      <= '0;
      r_acc_cnt   <= 9'd0;
      r_acc_hit   <= 1'b0;
      r_acc_fa    <= 8'd0;
      r_acc_fd    <= 8'd0;
      r_pass      <= 1'b0;
      r_err_count <= 9'd0;
      r_fail_addr <= 8'd0;
      r_fail_data <= 8'd0;
    end else if (w_start) begin
      r_mode    <= mode;
      r_cnt     <= 9'd0;
      r_addr    <= 8'd0;
      r_seen    <= '0;
      r_acc_cnt <= 9'd0;
      r_acc_hit <= 1'b0;
      r_acc_fa  <= 8'd0;
      r_acc_fd  <= 8'd0;
    end else if (r_state == S_READ) begin
      r_cnt <= r_cnt + 9'd1;
      if (r_addr != LAST_ADDR) r_addr <= r_addr + 8'd1;
      if (w_cmp) begin
        r_acc_cnt <= w_acc_cnt_nxt;
        r_acc_hit <= r_acc_hit | w_err;
        r_acc_fa  <= w_fa_nxt;
        r_acc_fd  <= w_fd_nxt;
        if (r_mode) r_seen[rddata] <= 1'b1;
      end
      if (w_last) begin
        r_pass      <= (w_acc_cnt_nxt == 9'd0);
        r_err_count <= w_acc_cnt_nxt;
        r_fail_addr <= w_fa_nxt;
        r_fail_data <= w_fd_nxt;
      end
    end
  end

  assign rdy       = (r_state != S_READ);
  assign valid     = (r_state == S_DONE);
  assign addr      = r_addr;
  assign wren      = 1'b0;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;

endmodule

// File: tb/tb_s_mem_readback.sv
// Bench for s_mem_readback: synchronous RAM model, scan-level reference model, directed scans.
module tb_s_mem_readback;
  localparam int LEN = 256;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       en     = 1'b0;
  logic       mode   = 1'b0;
  logic [7:0] rddata = 8'd0;
  logic       rdy;
  logic [7:0] addr;
  logic       wren;
  logic       valid;
  logic       pass;
  logic [8:0] err_count;
  logic [7:0] fail_addr;
  logic [7:0] fail_data;

  logic [7:0] mem [256];

  s_mem_readback #(.LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .rdy(rdy), .addr(addr),
    .rddata(rddata), .wren(wren), .valid(valid), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rddata <= mem[addr];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference result of one scan over the current RAM image.
  task automatic scan_ref(input bit md, output int cnt, output int fa, output int fd);
    bit seen [256];
    int v;
    bit bad;
    cnt = 0; fa = 0; fd = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      v   = int'(mem[i]);
      bad = md ? seen[v] : (v != i);
      if (md) seen[v] = 1'b1;
      if (bad) begin
        if (cnt == 0) begin fa = i; fd = v; end
        cnt++;
      end
    end
  endtask

  // Reference model and per-cycle compare.
  int m_ok = 0, m_vedge = -1, m_start = -1;
  int p_cnt = 0, p_fa = 0, p_fd = 0;
  int e_pass = 0, e_cnt = 0, e_fa = 0, e_fd = 0;
  int e_addr;
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_ok = 0; m_vedge = -1; m_start = -1;
        e_pass = 0; e_cnt = 0; e_fa = 0; e_fd = 0;
      end else if (en && cyc >= m_ok) begin
        scan_ref(mode, p_cnt, p_fa, p_fd);
        m_start = cyc;
        m_vedge = cyc + LEN + 1;
        m_ok    = cyc + LEN + 2;
      end
      @(negedge clk);
      if (!rst_n) begin
        m_ok = 0; m_vedge = -1; m_start = -1;
        e_pass = 0; e_cnt = 0; e_fa = 0; e_fd = 0;
      end
      if (cyc == m_vedge) begin
        e_pass = (p_cnt == 0) ? 1 : 0;
        e_cnt = p_cnt; e_fa = p_fa; e_fd = p_fd;
      end
      e_addr = (m_start < 0) ? 0 : ((cyc - m_start > LEN - 1) ? LEN - 1 : cyc - m_start);
      chk("rdy",       int'(rdy),       (cyc >= m_ok - 1) ? 1 : 0);
      chk("valid",     int'(valid),     (cyc == m_vedge) ? 1 : 0);
      chk("addr",      int'(addr),      e_addr);
      chk("wren",      int'(wren),      0);
      chk("pass",      int'(pass),      e_pass);
      chk("err_count", int'(err_count), e_cnt);
      chk("fail_addr", int'(fail_addr), e_fa);
      chk("fail_data", int'(fail_data), e_fd);
    end
  end

  task automatic mem_identity();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
  endtask

  task automatic wait_valid(output int tv);
    tv = -1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (valid) begin
        tv = cyc;
        break;
      end
    end
    if (tv < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL valid_timeout: got no valid pulse, expected one within 600 cycles");
    end
  endtask

  task automatic check_result(input string tag, input int ep, input int ec, input int efa, input int efd);
    chk({tag, ".pass"},      int'(pass),      ep);
    chk({tag, ".err_count"}, int'(err_count), ec);
    chk({tag, ".fail_addr"}, int'(fail_addr), efa);
    chk({tag, ".fail_data"}, int'(fail_data), efd);
  endtask

  task automatic run_scan(input string tag, input bit md,
                          input int ep, input int ec, input int efa, input int efd);
    int t0, tv;
    @(posedge clk); #1;
    en = 1'b1; mode = md;
    @(posedge clk); #1;
    t0 = cyc;
    en = 1'b0;
    wait_valid(tv);
    chk({tag, ".latency"}, tv - t0, 257);
    check_result(tag, ep, ec, efa, efd);
  endtask

  int xp [3] = '{1, 0, 0};
  int xc [3] = '{0, 1, 2};
  int xa [3] = '{0, 5, 66};
  int xd [3] = '{0, 7, 0};

  initial begin
    int tprev, tv;
    mem_identity();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.rdy",   int'(rdy),   1);
    chk("reset.valid", int'(valid), 0);
    chk("reset.addr",  int'(addr),  0);
    check_result("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    run_scan("identity_m0", 1'b0, 1, 0, 0, 0);

    mem[37] = 8'h99; mem[200] = 8'h00;
    run_scan("two_bad_m0", 1'b0, 0, 2, 37, 8'h99);
    mem_identity();

    mem[3] = 8'd250; mem[250] = 8'd3;
    run_scan("swap_m1", 1'b1, 1, 0, 0, 0);
    run_scan("swap_m0", 1'b0, 0, 2, 3, 250);
    mem_identity();

    mem[200] = 8'd10;
    run_scan("dup_m1", 1'b1, 0, 1, 200, 10);
    mem_identity();

    // Reset in the middle of a scan.
    @(posedge clk); #1;
    en = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.rdy",   int'(rdy),   1);
    chk("midrst.valid", int'(valid), 0);
    chk("midrst.addr",  int'(addr),  0);
    check_result("midrst", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_scan("after_rst", 1'b0, 1, 0, 0, 0);

    // Back-to-back scans with en held, extra en/mode activity while busy.
    @(posedge clk); #1;
    en = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    tprev = cyc - 1;
    for (int s = 0; s < 3; s++) begin
      repeat (50) @(posedge clk);
      #1;
      en = 1'b0; mode = 1'b1;
      @(posedge clk); #1;
      en = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      mode = 1'b0;
      wait_valid(tv);
      chk("b2b.gap", tv - tprev, 258);
      tprev = tv;
      check_result("b2b", xp[s], xc[s], xa[s], xd[s]);
      if (s == 0) begin
        mem[5] = 8'd7;
      end else if (s == 1) begin
        mem[5] = 8'd5; mem[66] = 8'd0; mem[100] = 8'h42;
      end else begin
        en = 1'b0;
      end
    end
    repeat (300) @(posedge clk);
    #1;
    check_result("hold", 0, 2, 66, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
